// File: rtl/mips_run_monitor.sv
// Run controller and writeback monitor for the pipelined mips core: reset sequencing, run gating,
// cycle/retire counting and a FWFT writeback-record FIFO. Define MIPS_RUN_MON_CYCLE_LIMIT_EN to enforce CYCLE_LIMIT.
module mips_run_monitor #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned CYCLE_LIMIT  = 10000,
    parameter logic [31:0] HALT_PC      = 32'h0000_3000,
    parameter bit          DROP_ON_FULL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_reset,
    output logic        cpu_run,
    input  logic        wb_en,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_pc,
    output logic [4:0]  rec_addr,
    output logic [31:0] rec_data,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt,
    output logic        done,
    output logic        overflow
);
    // state  | meaning
    // S_HOLD | core held in reset while the hold counter runs
    // S_RUN  | core released; counting cycles and writebacks
    // S_DONE | run finished on halt PC or cycle limit; FIFO still drainable

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned HW = $clog2(RST_CYCLES + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RST_CYCLES < 1 || CYCLE_LIMIT < 1) begin : g_param_check
        $error("mips_run_monitor: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    rec_t          mem [DEPTH];
    rec_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          recordable;
    logic          push;
    logic          pop;
    logic          drop;
    logic          halt_hit;
    logic          limit_hit;
    logic [31:0]   cycle_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Evaluated on the pre-pop occupancy, so a full FIFO stalls the core even in a cycle that pops.
    assign cpu_run    = (state == S_RUN) && (DROP_ON_FULL || !full);
    assign accept     = wb_en && cpu_run;
    assign recordable = accept && (wb_addr != 5'd0);
    assign push       = recordable && !full;
    // Only reachable when DROP_ON_FULL lets the core run into a full FIFO.
    assign drop       = recordable && full;
    assign rec_valid  = !empty;
    assign pop        = rec_valid && rec_ready;

    assign cycle_next = cycle_cnt + 32'd1;
    assign halt_hit   = accept && (wb_pc == HALT_PC);

`ifdef MIPS_RUN_MON_CYCLE_LIMIT_EN
    assign limit_hit = (cycle_next == 32'(CYCLE_LIMIT));
`else
    assign limit_hit = 1'b0;
`endif

    assign cpu_reset = (state == S_HOLD);
    assign done      = (state == S_DONE);

    // Head fields read as zero while empty so the port is clean after reset.
    assign head     = mem[rd_ptr[AW-1:0]];
    assign rec_pc   = rec_valid ? head.pc   : 32'd0;
    assign rec_addr = rec_valid ? head.addr : 5'd0;
    assign rec_data = rec_valid ? head.data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HW'(RST_CYCLES - 1)) begin
                        state <= S_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cycle_next;
                    if (halt_hit || limit_hit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_HOLD;
            endcase

            if (accept) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wb_pc, wb_addr, wb_data};
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench for mips_run_monitor: a stall-mode and a drop-mode instance (DEPTH=4) plus a
// CYCLE_LIMIT=20 instance, directed vectors, corner sequences and a queue-based random reference model.
module tb_mips_run_monitor;
    localparam int          DEPTH_T = 4;
    localparam logic [31:0] HALT    = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        wb_en;
    logic [31:0] wb_pc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rec_ready;

    logic [2:0]       cpu_reset_o, cpu_run_o, rec_valid_o, done_o, overflow_o;
    logic [2:0][31:0] rec_pc_o, rec_data_o, cycle_o, retire_o;
    logic [2:0][4:0]  rec_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    mips_run_monitor #(.DEPTH(DEPTH_T), .RST_CYCLES(4), .CYCLE_LIMIT(10000), .HALT_PC(HALT), .DROP_ON_FULL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset_o[0]), .cpu_run(cpu_run_o[0]),
        .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
        .rec_valid(rec_valid_o[0]), .rec_ready(rec_ready), .rec_pc(rec_pc_o[0]), .rec_addr(rec_addr_o[0]),
        .rec_data(rec_data_o[0]), .cycle_cnt(cycle_o[0]), .retire_cnt(retire_o[0]),
        .done(done_o[0]), .overflow(overflow_o[0]));

    mips_run_monitor #(.DEPTH(DEPTH_T), .RST_CYCLES(4), .CYCLE_LIMIT(10000), .HALT_PC(HALT), .DROP_ON_FULL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset_o[1]), .cpu_run(cpu_run_o[1]),
        .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
        .rec_valid(rec_valid_o[1]), .rec_ready(rec_ready), .rec_pc(rec_pc_o[1]), .rec_addr(rec_addr_o[1]),
        .rec_data(rec_data_o[1]), .cycle_cnt(cycle_o[1]), .retire_cnt(retire_o[1]),
        .done(done_o[1]), .overflow(overflow_o[1]));

    mips_run_monitor #(.DEPTH(8), .RST_CYCLES(4), .CYCLE_LIMIT(20), .HALT_PC(HALT), .DROP_ON_FULL(1'b0)) dut_c (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset_o[2]), .cpu_run(cpu_run_o[2]),
        .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
        .rec_valid(rec_valid_o[2]), .rec_ready(rec_ready), .rec_pc(rec_pc_o[2]), .rec_addr(rec_addr_o[2]),
        .rec_data(rec_data_o[2]), .cycle_cnt(cycle_o[2]), .retire_cnt(retire_o[2]),
        .done(done_o[2]), .overflow(overflow_o[2]));

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exp_valid;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_retire;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    vec_t tbl [7];
    rec_t mq [2][$];
    rec_t r;
    int   m_ret [2];
    int   m_cyc [2];
    bit   m_ovf [2];
    bit   exp_run, acc, full_m;
    int   nxt, popn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_en   = 1'b0;
        wb_pc   = 32'd0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
    endtask

    task automatic offer(input int a);
        wb_en   = 1'b1;
        wb_addr = 5'(a);
        wb_data = 32'(a) * 32'h11;
        wb_pc   = 32'h200 + 32'(4 * a);
    endtask

    task automatic check_zero(input int i);
        chk($sformatf("zero%0d_cpu_reset", i), cpu_reset_o[i], 1);
        chk($sformatf("zero%0d_cpu_run", i), cpu_run_o[i], 0);
        chk($sformatf("zero%0d_rec_valid", i), rec_valid_o[i], 0);
        chk($sformatf("zero%0d_done", i), done_o[i], 0);
        chk($sformatf("zero%0d_overflow", i), overflow_o[i], 0);
        chk($sformatf("zero%0d_cycle", i), cycle_o[i], 0);
        chk($sformatf("zero%0d_retire", i), retire_o[i], 0);
        chk($sformatf("zero%0d_rec_pc", i), rec_pc_o[i], 0);
        chk($sformatf("zero%0d_rec_addr", i), rec_addr_o[i], 0);
        chk($sformatf("zero%0d_rec_data", i), rec_data_o[i], 0);
    endtask

    // Leaves the bench just after the edge that starts the first RUN cycle.
    task automatic do_reset(input bit check);
        reset     = 1'b1;
        rec_ready = 1'b0;
        idle();
        cyc();
        cyc();
        if (check) begin
            smp();
            check_zero(0);
            check_zero(1);
        end
        cyc();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (check) begin
                smp();
                chk($sformatf("hold%0d_cpu_reset", i), cpu_reset_o[0], 1);
                chk($sformatf("hold%0d_cpu_run", i), cpu_run_o[0], 0);
                chk($sformatf("hold%0d_cycle", i), cycle_o[0], 0);
            end
            cyc();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h00, 32'd0};
        tbl[1] = '{1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 32'h11, 32'd1};
        tbl[2] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22, 32'd2};
        tbl[3] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 32'd3};
        tbl[4] = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd4, 32'h44, 32'd4};
        tbl[5] = '{1'b0, 5'd0, 32'h00, 1'b1, 5'd5, 32'h55, 32'd5};
        tbl[6] = '{1'b0, 5'd0, 32'h00, 1'b0, 5'd0, 32'h00, 32'd5};

        reset     = 1'b1;
        rec_ready = 1'b0;
        idle();

        // Reset release: four held cycles, then run.
        do_reset(1'b1);
        smp();
        chk("release_cpu_run", cpu_run_o[0], 1);
        chk("release_cpu_reset", cpu_reset_o[0], 0);
        chk("release_cycle", cycle_o[0], 0);

        // Five back-to-back writebacks drained immediately.
        do_reset(1'b0);
        rec_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wb_en   = tbl[i].en;
            wb_addr = tbl[i].addr;
            wb_data = tbl[i].data;
            wb_pc   = 32'h100 + 32'(4 * i);
            smp();
            chk($sformatf("vec%0d_run", i), cpu_run_o[0], 1);
            chk($sformatf("vec%0d_valid", i), rec_valid_o[0], tbl[i].exp_valid);
            chk($sformatf("vec%0d_addr", i), rec_addr_o[0], tbl[i].exp_addr);
            chk($sformatf("vec%0d_data", i), rec_data_o[0], tbl[i].exp_data);
            chk($sformatf("vec%0d_retire", i), retire_o[0], tbl[i].exp_retire);
            cyc();
        end

        // Stall mode: fill, stall, then resume with no loss.
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) begin
            offer((c < 4) ? c + 1 : 5);
            smp();
            chk($sformatf("stall%0d_run", c), cpu_run_o[0], (c < 4) ? 1 : 0);
            cyc();
        end
        smp();
        chk("stall_retire", retire_o[0], 4);
        chk("stall_overflow", overflow_o[0], 0);
        chk("stall_valid", rec_valid_o[0], 1);
        chk("stall_head", rec_addr_o[0], 1);
        chk("stall_prepop_run", cpu_run_o[0], 0);
        rec_ready = 1'b1;
        popn = 2;
        nxt  = 5;
        for (int c = 0; c < 30 && popn <= 6; c++) begin
            cyc();
            if (nxt <= 6) offer(nxt);
            else idle();
            smp();
            if (c == 0) chk("stall_resume_run", cpu_run_o[0], 1);
            if (rec_valid_o[0]) begin
                chk($sformatf("stall_pop%0d_addr", popn), rec_addr_o[0], popn);
                chk($sformatf("stall_pop%0d_data", popn), rec_data_o[0], 32'(popn) * 32'h11);
                popn++;
            end
            if (wb_en && cpu_run_o[0]) nxt++;
        end
        chk("stall_all_popped", popn, 7);
        chk("stall_final_retire", retire_o[0], 6);
        chk("stall_final_overflow", overflow_o[0], 0);
        idle();

        // Drop mode: same stimulus, two records discarded.
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) begin
            offer(c + 1);
            smp();
            chk($sformatf("drop%0d_run", c), cpu_run_o[1], 1);
            chk($sformatf("drop%0d_overflow", c), overflow_o[1], (c == 5) ? 1 : 0);
            cyc();
        end
        idle();
        smp();
        chk("drop_retire", retire_o[1], 6);
        chk("drop_overflow", overflow_o[1], 1);
        chk("drop_valid", rec_valid_o[1], 1);
        rec_ready = 1'b1;
        popn = 1;
        for (int c = 0; c < 12; c++) begin
            if (rec_valid_o[1]) begin
                chk($sformatf("drop_pop%0d_addr", popn), rec_addr_o[1], popn);
                popn++;
            end
            cyc();
            smp();
        end
        chk("drop_stored", popn - 1, 4);

        // Halt PC: recorded, done next cycle, reset clears.
        do_reset(1'b0);
        rec_ready = 1'b1;
        wb_en   = 1'b1;
        wb_pc   = HALT;
        wb_addr = 5'd8;
        wb_data = 32'hDEAD_BEEF;
        smp();
        chk("halt_run_before", cpu_run_o[0], 1);
        chk("halt_done_before", done_o[0], 0);
        cyc();
        idle();
        smp();
        chk("halt_done", done_o[0], 1);
        chk("halt_run", cpu_run_o[0], 0);
        chk("halt_valid", rec_valid_o[0], 1);
        chk("halt_pc", rec_pc_o[0], HALT);
        chk("halt_addr", rec_addr_o[0], 8);
        chk("halt_data", rec_data_o[0], 32'hDEAD_BEEF);
        chk("halt_retire", retire_o[0], 1);
        chk("halt_cycle", cycle_o[0], 1);
        offer(3);
        cyc();
        smp();
        chk("halt_sticky", done_o[0], 1);
        chk("halt_drained", rec_valid_o[0], 0);
        chk("halt_cycle_frozen", cycle_o[0], 1);
        chk("halt_no_accept", retire_o[0], 1);
        reset = 1'b1;
        idle();
        cyc();
        smp();
        check_zero(0);

        // Cycle limit instance.
        do_reset(1'b0);
        for (int k = 0; k < 26; k++) begin
            smp();
`ifdef MIPS_RUN_MON_CYCLE_LIMIT_EN
            chk($sformatf("limit%0d_cycle", k), cycle_o[2], (k < 20) ? k : 20);
            chk($sformatf("limit%0d_done", k), done_o[2], (k >= 20) ? 1 : 0);
            chk($sformatf("limit%0d_run", k), cpu_run_o[2], (k >= 20) ? 0 : 1);
`else
            chk($sformatf("limit%0d_cycle", k), cycle_o[2], k);
            chk($sformatf("limit%0d_done", k), done_o[2], 0);
            chk($sformatf("limit%0d_run", k), cpu_run_o[2], 1);
`endif
            cyc();
        end

        // Random traffic on both DEPTH=4 instances against a queue model.
        do_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ret[i] = 0;
            m_cyc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        for (int t = 0; t < 400; t++) begin
            wb_en     = ($urandom_range(0, 9) < 7);
            wb_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb_data   = $urandom;
            wb_pc     = $urandom;
            if (wb_pc == HALT) wb_pc = wb_pc ^ 32'd4;
            rec_ready = ($urandom_range(0, 1) == 1);
            smp();
            for (int i = 0; i < 2; i++) begin
                full_m  = (mq[i].size() == DEPTH_T);
                exp_run = (i == 1) || !full_m;
                chk($sformatf("rand%0d_run", i), cpu_run_o[i], exp_run);
                chk($sformatf("rand%0d_valid", i), rec_valid_o[i], (mq[i].size() != 0));
                if (mq[i].size() != 0) begin
                    chk($sformatf("rand%0d_pc", i), rec_pc_o[i], mq[i][0].pc);
                    chk($sformatf("rand%0d_addr", i), rec_addr_o[i], mq[i][0].addr);
                    chk($sformatf("rand%0d_data", i), rec_data_o[i], mq[i][0].data);
                end
                chk($sformatf("rand%0d_retire", i), retire_o[i], m_ret[i]);
                chk($sformatf("rand%0d_cycle", i), cycle_o[i], m_cyc[i]);
                chk($sformatf("rand%0d_overflow", i), overflow_o[i], m_ovf[i]);
                chk($sformatf("rand%0d_done", i), done_o[i], 0);
                acc = wb_en && exp_run;
                if (mq[i].size() != 0 && rec_ready) void'(mq[i].pop_front());
                if (acc && wb_addr != 5'd0) begin
                    if (full_m) begin
                        m_ovf[i] = 1'b1;
                    end else begin
                        r.pc   = wb_pc;
                        r.addr = wb_addr;
                        r.data = wb_data;
                        mq[i].push_back(r);
                    end
                end
                if (acc) m_ret[i]++;
                m_cyc[i]++;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_run_monitor.md
# mips_run_monitor

Run controller and writeback monitor that sits beside the pipelined `mips` core inside the simulation/FPGA harness. It sequences the core's reset, gates core progress with a run enable, and counts cycles and retired writebacks. It stops the run on a halt PC or a cycle limit, and buffers register-writeback records in a parametrised FIFO that a trace consumer drains over a valid/ready port.

## Interface
Parameters:
- `DEPTH`, 8: record FIFO entries; power of two, ≥2.
- `RST_CYCLES`, 4: extra cycles `cpu_reset` is held after `reset` falls; ≥1.
- `CYCLE_LIMIT`, 10000: RUN cycles before forced stop; ≥1.
- `HALT_PC`, 32'h0000_3000: writeback PC that ends the run.
- `DROP_ON_FULL`, 0: 0 = stall the core when the FIFO is full; 1 = drop records and set `overflow`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cpu_reset` out 1: reset to core.
- `cpu_run` out 1: core clock enable.
- `wb_en` in 1: core register writeback this cycle.
- `wb_pc` in 32: PC of the writing instruction.
- `wb_addr` in 5: destination register.
- `wb_data` in 32: written value.
- `rec_valid` out 1: FIFO head valid.
- `rec_ready` in 1: consumer accepts the head.
- `rec_pc` out 32: head record PC.
- `rec_addr` out 5: head record register.
- `rec_data` out 32: head record data.
- `cycle_cnt` out 32: RUN cycles elapsed.
- `retire_cnt` out 32: accepted writebacks.
- `done` out 1: run finished (sticky).
- `overflow` out 1: record dropped (sticky).

## Operation
- States:
  - HOLD: `cpu_reset`=1.
  - RUN: `cpu_reset`=0.
  - DONE: `cpu_reset`=0, `done`=1.
- `reset` high forces HOLD from any state. It clears the hold counter, both counts, the FIFO, `done` and `overflow`.
- HOLD → RUN after `RST_CYCLES` clocks with `reset` low.
- `cpu_run` is combinational: 1 when the state is RUN and the FIFO is not full. When `DROP_ON_FULL`=1, the FIFO-not-full condition is dropped.
- An accepted writeback is `wb_en && cpu_run`. `wb_*` is ignored otherwise.
- On an accepted writeback:
  - `retire_cnt`+1.
  - If `wb_addr`≠0, push {pc, addr, data}.
  - If the FIFO is full with `DROP_ON_FULL`=1, the record is discarded and `overflow` is set.
- `wb_addr`=0 writebacks are counted but never recorded.
- RUN → DONE on an accepted writeback with `wb_pc`==`HALT_PC`. That writeback is still counted and recorded.
- RUN → DONE when `cycle_cnt` becomes `CYCLE_LIMIT`; see Configuration.
- `cycle_cnt` increments every RUN cycle, including stalled cycles. It is 32-bit and wraps modulo 2^32.
- DONE persists until `reset`. The FIFO remains drainable in DONE.
- FIFO behaviour:
  - First-word-fall-through; the head is visible while `rec_valid`=1.
  - A pop happens when `rec_valid && rec_ready`.
  - Pointers are log2(DEPTH) bits with an extra wrap bit for full/empty detection.
  - A simultaneous push and pop when full: the pop frees a slot next cycle. `cpu_run` stays 0 this cycle because it is evaluated on the pre-pop count.
  - A simultaneous push and pop when empty: the record appears on `rec_*` the next cycle.

## Timing
- During and after `reset`:
  - `cpu_reset`=1.
  - `cpu_run`=0, `rec_valid`=0, `done`=0, `overflow`=0.
  - `cycle_cnt`=0, `retire_cnt`=0.
  - `rec_*` data=0.
- First `cpu_run`=1 cycle is exactly `RST_CYCLES`+1 clocks after the last clock with `reset`=1.
- Record latency: push at edge N gives `rec_valid`=1 in cycle N+1.
- Counters and `done` are registered; each updates at the edge of the triggering cycle.
- `cpu_run` drops in the same cycle the FIFO reads full.
- `reset` asserted mid-RUN: at the next edge the block returns to HOLD, and in-flight FIFO contents are discarded.

## Configuration
- `MIPS_RUN_MON_CYCLE_LIMIT_EN` defined: the cycle limit is enforced. The final `cycle_cnt` equals `CYCLE_LIMIT`.
- Macro undefined: only `HALT_PC` ends the run. `cycle_cnt` free-runs and wraps, and `CYCLE_LIMIT` is unused.

## Test plan
- Reset release with `RST_CYCLES`=4 → `cpu_reset` high for 4 clocks after `reset` falls, then `cpu_run`=1; all outputs zero before that.
- Five writebacks (addr 1..5, data 0x11..0x55) with `rec_ready`=1 → records out in order, one cycle after each push; `retire_cnt`=5.
- `DEPTH`=4, `DROP_ON_FULL`=0, `rec_ready`=0, 6 writebacks offered → 4 stored, `cpu_run`=0 while full, `overflow`=0. Raising `rec_ready` resumes the run with no loss.
- `DROP_ON_FULL`=1, same stimulus → 4 stored, 2 dropped, `overflow`=1, `retire_cnt`=6.
- Writeback at `wb_pc`=0x3000, addr 8 → recorded, `done`=1 next cycle, `cpu_run`=0. Asserting `reset` afterwards clears everything.
- Macro defined, `CYCLE_LIMIT`=20, no halt → `done` after 20 RUN cycles, `cycle_cnt`=20. Macro undefined → no stop.
